// File: rtl/feature_bank_sched_pkg.sv
// Shared definitions for the feature_in ping-pong bank scheduler:
// bank state encodings, default address width and bank_state packing.
package feature_bank_sched_pkg;

  localparam int ADDR_W_DEF   = 15;
  localparam int NUM_BANKS    = 2;
  localparam int BANK_STATE_W = 2;

  typedef enum logic [BANK_STATE_W-1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // bank_state port layout: bank1 in [3:2], bank0 in [1:0]
  function automatic logic [2*BANK_STATE_W-1:0] pack_bank_state(input bank_state_e b0,
                                                                 input bank_state_e b1);
    return {b1, b0};
  endfunction

endpackage

// File: rtl/fbank_slot.sv
// Lifecycle register for one feature_in bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
module fbank_slot
  import feature_bank_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fill,
  input  logic        full,
  input  logic        drain,
  input  logic        free,
  output bank_state_e state
);

  bank_state_e next_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BANK_EMPTY;
    else      state <= next_state;
  end

  // Each event only advances the bank from the state it is meant for.
  always_comb begin
    next_state = state;
    case (state)
      BANK_EMPTY:    if (fill)  next_state = BANK_FILLING;
      BANK_FILLING:  if (full)  next_state = BANK_FULL;
      BANK_FULL:     if (drain) next_state = BANK_DRAINING;
      BANK_DRAINING: if (free)  next_state = BANK_EMPTY;
      default:       next_state = BANK_EMPTY;
    endcase
  end

endmodule

// File: rtl/feature_bank_sched.sv
// Ping-pong scheduler for the two feature_in banks: grants banks to the loader,
// generates write addresses, and hands FULL banks to the CLP in fill order.
module feature_bank_sched
  import feature_bank_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_len,
  output logic              load_grant,
  output logic              load_bank,
  input  logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              load_done,
  input  logic              comp_req,
  output logic              comp_grant,
  output logic              comp_bank,
  input  logic              comp_done,
  output logic [3:0]        bank_state,
  output logic              busy,
  output logic              err
);

  bank_state_e          slot_state [NUM_BANKS];
  logic [NUM_BANKS-1:0] fill;
  logic [NUM_BANKS-1:0] full;
  logic [NUM_BANKS-1:0] drain;
  logic [NUM_BANKS-1:0] free;

  logic              fill_ptr;
  logic              drain_ptr;
  logic              load_active;
  logic              comp_active;
  logic [ADDR_W-1:0] counter;
  logic [ADDR_W-1:0] len;

  logic load_fire;
  logic load_finish;
  logic comp_fire;
  logic comp_free;
  logic err_set;

  // Grants look only at registered bank state, so a bank changed this cycle waits a cycle.
  always_comb begin
    load_fire   = load_req && !load_active && (slot_state[fill_ptr] == BANK_EMPTY);
    load_finish = load_active &&
                  ((len == '0) || (wr_en && (counter == len - ADDR_W'(1))));
    comp_fire   = comp_req && !comp_active && (slot_state[drain_ptr] == BANK_FULL);
    comp_free   = comp_done && comp_active;
    err_set     = (wr_en && (!load_active || (len == '0))) || (comp_done && !comp_active);
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_slot
    assign fill[i]  = load_fire   && (int'(fill_ptr)  == i);
    assign full[i]  = load_finish && (int'(load_bank) == i);
    assign drain[i] = comp_fire   && (int'(drain_ptr) == i);
    assign free[i]  = comp_free   && (int'(comp_bank) == i);

    fbank_slot u_slot (
      .clk   (clk),
      .rst   (rst),
      .fill  (fill[i]),
      .full  (full[i]),
      .drain (drain[i]),
      .free  (free[i]),
      .state (slot_state[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_ptr    <= 1'b0;
      drain_ptr   <= 1'b0;
      load_active <= 1'b0;
      comp_active <= 1'b0;
      counter     <= '0;
      len         <= '0;
      load_grant  <= 1'b0;
      load_bank   <= 1'b0;
      load_done   <= 1'b0;
      comp_grant  <= 1'b0;
      comp_bank   <= 1'b0;
      err         <= 1'b0;
    end else begin
      load_grant <= load_fire;
      load_done  <= load_finish;
      comp_grant <= comp_fire;
      err        <= err | err_set;

      if (load_fire) begin
        fill_ptr    <= ~fill_ptr;
        load_bank   <= fill_ptr;
        len         <= load_len;
        counter     <= '0;
        load_active <= 1'b1;
      end else begin
        if (load_finish) load_active <= 1'b0;
        if (load_active && wr_en && (len != '0)) counter <= counter + ADDR_W'(1);
      end

      if (comp_fire) begin
        drain_ptr   <= ~drain_ptr;
        comp_bank   <= drain_ptr;
        comp_active <= 1'b1;
      end else if (comp_free) begin
        comp_active <= 1'b0;
      end
    end
  end

  assign wr_addr    = counter;
  assign bank_state = pack_bank_state(slot_state[0], slot_state[1]);
  assign busy       = (bank_state != 4'b0000) || load_req || comp_req;

endmodule

// File: tb/tb_feature_bank_sched.sv
// Self-checking bench for feature_bank_sched: directed scenarios plus randomized
// loader/CLP traffic, all compared against a transaction-level reference model.
module tb_feature_bank_sched;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_req = 1'b0;
  logic [AW-1:0] load_len = '0;
  logic          load_grant;
  logic          load_bank;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr;
  logic          load_done;
  logic          comp_req = 1'b0;
  logic          comp_grant;
  logic          comp_bank;
  logic          comp_done = 1'b0;
  logic [3:0]    bank_state;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  feature_bank_sched #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .load_len   (load_len),
    .load_grant (load_grant),
    .load_bank  (load_bank),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .load_done  (load_done),
    .comp_req   (comp_req),
    .comp_grant (comp_grant),
    .comp_bank  (comp_bank),
    .comp_done  (comp_done),
    .bank_state (bank_state),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Reference model: bank lifecycle per bank, loads alternate banks, and the CLP
  // is served strictly in the order the tiles were granted to the loader.
  int  m_bank [2];
  int  order_q [$];
  int  m_loads;
  bit  m_loading;
  bit  m_computing;
  int  m_load_bank;
  int  m_comp_bank;
  int  m_len;
  int  m_cnt;
  bit  m_lg;
  bit  m_ld;
  bit  m_cg;
  bit  m_err;

  task automatic modelReset();
    m_bank[0] = 0; m_bank[1] = 0;
    order_q.delete();
    m_loads = 0; m_loading = 0; m_computing = 0;
    m_load_bank = 0; m_comp_bank = 0; m_len = 0; m_cnt = 0;
    m_lg = 0; m_ld = 0; m_cg = 0; m_err = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    int  nb [2];
    bit  n_loading, n_computing;
    int  n_cnt;
    nb[0] = m_bank[0]; nb[1] = m_bank[1];
    n_loading = m_loading; n_computing = m_computing; n_cnt = m_cnt;
    m_lg = 0; m_ld = 0; m_cg = 0;

    if (wr_en && (!m_loading || m_len == 0)) m_err = 1;
    if (comp_done && !m_computing) m_err = 1;

    if (m_loading) begin
      if (m_len == 0) begin
        nb[m_load_bank] = 2; n_loading = 0; m_ld = 1;
      end else if (wr_en) begin
        if (m_cnt == m_len - 1) begin
          nb[m_load_bank] = 2; n_loading = 0; m_ld = 1;
        end
        n_cnt = m_cnt + 1;
      end
    end else if (load_req && m_bank[m_loads % 2] == 0) begin
      m_load_bank = m_loads % 2;
      nb[m_load_bank] = 1;
      n_loading = 1; m_len = int'(load_len); n_cnt = 0; m_lg = 1;
      order_q.push_back(m_load_bank);
      m_loads++;
    end

    if (m_computing) begin
      if (comp_done) begin
        nb[m_comp_bank] = 0; n_computing = 0;
      end
    end else if (comp_req && order_q.size() > 0 && m_bank[order_q[0]] == 2) begin
      m_comp_bank = order_q.pop_front();
      nb[m_comp_bank] = 3; n_computing = 1; m_cg = 1;
    end

    m_bank[0] = nb[0]; m_bank[1] = nb[1];
    m_loading = n_loading; m_computing = n_computing; m_cnt = n_cnt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic [3:0] exp_bs;
    bit         exp_busy;
    exp_bs   = {m_bank[1][1:0], m_bank[0][1:0]};
    exp_busy = (m_bank[0] != 0) || (m_bank[1] != 0) || load_req || comp_req;
    checkOutput("load_grant", {31'b0, load_grant}, {31'b0, m_lg});
    checkOutput("load_bank",  {31'b0, load_bank},  m_load_bank);
    checkOutput("load_done",  {31'b0, load_done},  {31'b0, m_ld});
    checkOutput("comp_grant", {31'b0, comp_grant}, {31'b0, m_cg});
    checkOutput("comp_bank",  {31'b0, comp_bank},  m_comp_bank);
    checkOutput("bank_state", {28'b0, bank_state}, {28'b0, exp_bs});
    checkOutput("busy",       {31'b0, busy},       {31'b0, exp_busy});
    checkOutput("err",        {31'b0, err},        {31'b0, m_err});
    if (m_loading) checkOutput("wr_addr", {17'b0, wr_addr}, m_cnt);
  endtask

  // Apply one cycle of inputs, clock it, and compare everything against the model.
  task automatic applyStimulus(input bit lr, input logic [AW-1:0] ln, input bit we,
                               input bit cr, input bit cd);
    load_req = lr; load_len = ln; wr_en = we; comp_req = cr; comp_done = cd;
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic resetDut();
    rst = 1'b0;
    load_req = 0; load_len = '0; wr_en = 0; comp_req = 0; comp_done = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    checkOutput("reset_wr_addr", {17'b0, wr_addr}, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Request a bank, then write the whole tile; ends in the load_done cycle.
  task automatic fillTile(input int n);
    applyStimulus(1, AW'(n), 0, 0, 0);
    for (int i = 0; i < n; i++) applyStimulus(0, AW'(n), 1, 0, 0);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          lr, we, cr, cd;
    logic [AW-1:0] ln;
    int          words_left, comp_wait;

    // Single tile of four words into bank0
    resetDut();
    applyStimulus(1, AW'(4), 0, 0, 0);
    checkOutput("t1_grant", {31'b0, load_grant}, 1);
    checkOutput("t1_bank", {31'b0, load_bank}, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1_wr_addr", {17'b0, wr_addr}, i);
      applyStimulus(0, AW'(4), 1, 0, 0);
    end
    checkOutput("t1_done", {31'b0, load_done}, 1);
    checkOutput("t1_state", {28'b0, bank_state}, 32'h2);

    // Compute grant on bank0 and load grant on bank1 in the same cycle
    applyStimulus(1, AW'(2), 0, 1, 0);
    checkOutput("t2_cgrant", {31'b0, comp_grant}, 1);
    checkOutput("t2_cbank", {31'b0, comp_bank}, 0);
    checkOutput("t2_lgrant", {31'b0, load_grant}, 1);
    checkOutput("t2_lbank", {31'b0, load_bank}, 1);
    checkOutput("t2_state", {28'b0, bank_state}, 32'h7);

    // Both banks FULL: a held load_req waits until bank0 is freed
    resetDut();
    fillTile(1);
    fillTile(1);
    checkOutput("t3_full", {28'b0, bank_state}, 32'hA);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, AW'(3), 0, 0, 0);
      checkOutput("t3_wait", {31'b0, load_grant}, 0);
    end
    applyStimulus(1, AW'(3), 0, 1, 0);
    checkOutput("t3_cgrant", {31'b0, comp_grant}, 1);
    applyStimulus(1, AW'(3), 0, 0, 1);
    checkOutput("t3_wait_free", {31'b0, load_grant}, 0);
    applyStimulus(1, AW'(3), 0, 0, 0);
    checkOutput("t3_lgrant", {31'b0, load_grant}, 1);
    checkOutput("t3_lbank", {31'b0, load_bank}, 0);

    // Three tiles b0,b1,b0 drained in fill order
    resetDut();
    fillTile(2);
    applyStimulus(0, '0, 0, 1, 0);
    checkOutput("t4_cbank0", {31'b0, comp_bank}, 0);
    fillTile(2);
    applyStimulus(0, '0, 0, 0, 1);
    applyStimulus(0, '0, 0, 0, 0);
    fillTile(1);
    checkOutput("t4_lbank2", {31'b0, load_bank}, 0);
    applyStimulus(0, '0, 0, 1, 0);
    checkOutput("t4_cbank1", {31'b0, comp_bank}, 1);
    applyStimulus(0, '0, 0, 0, 1);
    applyStimulus(0, '0, 0, 0, 0);
    applyStimulus(0, '0, 0, 1, 0);
    checkOutput("t4_cbank2", {31'b0, comp_bank}, 0);
    checkOutput("t4_cgrant2", {31'b0, comp_grant}, 1);

    // Protocol errors are sticky and leave the banks alone
    resetDut();
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("t5_err_wr", {31'b0, err}, 1);
    checkOutput("t5_state", {28'b0, bank_state}, 0);
    applyStimulus(0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, 0, 0);
    checkOutput("t5_err_sticky", {31'b0, err}, 1);
    checkOutput("t5_state2", {28'b0, bank_state}, 0);

    // Zero-length tile: FULL the cycle after grant
    resetDut();
    applyStimulus(1, '0, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 0);
    checkOutput("t6_zero_done", {31'b0, load_done}, 1);
    checkOutput("t6_zero_state", {28'b0, bank_state}, 32'h2);

    // Asynchronous reset with bank0 FILLING and bank1 DRAINING
    resetDut();
    fillTile(1);
    applyStimulus(0, '0, 0, 1, 0);
    applyStimulus(0, '0, 0, 0, 1);
    applyStimulus(0, '0, 0, 0, 0);
    fillTile(1);
    applyStimulus(0, '0, 0, 1, 0);
    applyStimulus(1, AW'(3), 0, 0, 0);
    applyStimulus(0, AW'(3), 1, 0, 0);
    checkOutput("t7_pre_state", {28'b0, bank_state}, 32'hD);
    #2;
    rst = 1'b0;
    load_req = 0; load_len = '0; wr_en = 0; comp_req = 0; comp_done = 0;
    modelReset();
    #1;
    checkAll();
    checkOutput("t7_async_wr_addr", {17'b0, wr_addr}, 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1, AW'(1), 0, 0, 0);
    checkOutput("t7_regrant", {31'b0, load_grant}, 1);
    checkOutput("t7_rebank", {31'b0, load_bank}, 0);

    // Randomized legal traffic from a loader agent and a CLP agent
    resetDut();
    lr = 0; cr = 0; ln = '0; words_left = 0; comp_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      we = 0; cd = 0;
      if (m_lg) begin
        lr = 0;
        words_left = m_len;
      end else if (!lr && !m_loading && $urandom_range(3) == 0) begin
        lr = 1;
        ln = AW'($urandom_range(5));
      end
      if (m_loading && words_left > 0 && $urandom_range(1) == 1) begin
        we = 1;
        words_left--;
      end
      if (m_cg) begin
        cr = 0;
        comp_wait = $urandom_range(4);
      end else if (!cr && !m_computing && $urandom_range(2) == 0) begin
        cr = 1;
      end
      if (m_computing) begin
        if (comp_wait == 0) cd = 1;
        else comp_wait--;
      end
      applyStimulus(lr, ln, we, cr, cd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
